// File: rtl/crm_pkg.sv
// Shared definitions for the CRAM slice: commit FSM states, diagnostic
// function codes and the parity generator used at write and read time.
package crm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2
    } crm_state_e;

    localparam logic [2:0] FUNC_CLR_PERR = 3'd6;
    localparam logic [2:0] FUNC_COMMIT   = 3'd7;

    localparam int PAR_VEC_W = 64;

    // Parity bit that makes the total ones count over {vec, parity} odd when odd=1.
    function automatic logic gen_parity(input logic [PAR_VEC_W-1:0] vec, input logic odd);
        return (^vec) ^ odd;
    endfunction

endpackage

// File: rtl/crm_ram.sv
// CRAM storage array: one write port, synchronous registered read.
// Only the output register is reset; stored contents are never cleared.
module crm_ram #(
    parameter int DATA_W = 18,
    parameter int ADR_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/crm_slice.sv
// One slice of the control RAM: registered microword read path with parity
// checking, plus a diagnostic staging/commit path and group read-back onto the ebus.
module crm_slice #(
    parameter int ADR_W   = 11,
    parameter int GRP_W   = 4,
    parameter int N_GRP   = 4,
    parameter int PAR_ODD = 1
) (
    input  logic                   clk_crm_h,
    input  logic                   mr_reset_h,
    input  logic [ADR_W-1:0]       cra_adr_c_h,
    input  logic [2:0]             diag_func_h,
    input  logic                   diag_load_func_l,
    input  logic                   diag_read_func_l,
    input  logic [GRP_W-1:0]       diag_data_h,
    input  logic                   cram_mark_h,
    output logic [GRP_W*N_GRP-1:0] crm_word_h,
    output logic                   crm_mark_h,
    output logic                   cram_par_h,
    output logic [GRP_W-1:0]       ebus_d_e_h,
    output logic                   ebus_d_en_h,
    output logic [N_GRP-1:0]       dia_func_l,
    output logic                   crm_busy_h,
    output logic                   par_err_h
);
    import crm_pkg::*;

    localparam int   WORD_W  = GRP_W * N_GRP;
    localparam int   ENT_W   = WORD_W + 2;
    localparam int   PAD_W   = PAR_VEC_W - WORD_W - 1;
    localparam logic ODD_SEL = (PAR_ODD != 0);

    crm_state_e        state_q;
    crm_state_e        state_d;
    logic [ADR_W-1:0]  adr_q;
    logic [GRP_W-1:0]  stage_q [N_GRP];
    logic              stage_mark_q;
    logic              rd_vld_q;
    logic              par_err_q;
    logic              busy;
    logic              ram_we;
    logic [ENT_W-1:0]  ram_wdata;
    logic [ENT_W-1:0]  ram_rdata;
    logic              load_act;
    logic              read_act;
    logic              load_commit;
    logic              load_clr;
    logic [N_GRP-1:0]  grp_sel;
    logic [WORD_W-1:0] stage_word;
    logic [GRP_W-1:0]  rd_grp;
    logic              rd_mismatch;

    // Strobes are honoured only in IDLE; a load wins over a simultaneous read.
    assign load_act    = !diag_load_func_l && (state_q == ST_IDLE);
    assign read_act    = !diag_read_func_l && diag_load_func_l && (state_q == ST_IDLE);
    assign load_commit = load_act && (diag_func_h == FUNC_COMMIT);
    assign load_clr    = load_act && (diag_func_h == FUNC_CLR_PERR);

    always_comb begin
        grp_sel    = '0;
        rd_grp     = '0;
        stage_word = '0;
        for (int g = 0; g < N_GRP; g++) begin
            grp_sel[g] = (diag_func_h == 3'(g));
            if (diag_func_h == 3'(g)) begin
                rd_grp = crm_word_h[g*GRP_W +: GRP_W];
            end
            stage_word[g*GRP_W +: GRP_W] = stage_q[g];
        end
    end

    assign ram_wdata = {gen_parity({{PAD_W{1'b0}}, stage_mark_q, stage_word}, ODD_SEL),
                        stage_mark_q, stage_word};

    crm_ram #(
        .DATA_W (ENT_W),
        .ADR_W  (ADR_W)
    ) u_ram (
        .clk   (clk_crm_h),
        .rst   (mr_reset_h),
        .we    (ram_we),
        .waddr (adr_q),
        .wdata (ram_wdata),
        .raddr (adr_q),
        .rdata (ram_rdata)
    );

    assign crm_word_h = ram_rdata[WORD_W-1:0];
    assign crm_mark_h = ram_rdata[WORD_W];
    assign cram_par_h = ram_rdata[WORD_W+1];

    // The check is combinational so the error flags in the cycle the bad word appears.
    assign rd_mismatch = rd_vld_q &&
        (gen_parity({{PAD_W{1'b0}}, crm_mark_h, crm_word_h}, ODD_SEL) != cram_par_h);
    assign par_err_h   = par_err_q | rd_mismatch;

    always_ff @(posedge clk_crm_h) begin
        if (mr_reset_h) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load_commit) state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_VERIFY;
            ST_VERIFY: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A reset landing on the WRITE cycle must not corrupt the target word.
    always_comb begin
        busy   = 1'b0;
        ram_we = 1'b0;
        case (state_q)
            ST_WRITE: begin
                busy   = 1'b1;
                ram_we = !mr_reset_h;
            end
            ST_VERIFY: busy = 1'b1;
            default: ;
        endcase
    end

    assign crm_busy_h = busy;

    always_ff @(posedge clk_crm_h) begin
        if (mr_reset_h) begin
            adr_q        <= '0;
            stage_mark_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            par_err_q    <= 1'b0;
            ebus_d_e_h   <= '0;
            ebus_d_en_h  <= 1'b0;
            dia_func_l   <= '1;
            for (int g = 0; g < N_GRP; g++) begin
                stage_q[g] <= '0;
            end
        end else begin
            rd_vld_q <= 1'b1;
            if (!busy) begin
                adr_q <= cra_adr_c_h;
            end
            if (load_clr) begin
                par_err_q <= 1'b0;
            end else if (rd_mismatch) begin
                par_err_q <= 1'b1;
            end
            for (int g = 0; g < N_GRP; g++) begin
                if (load_act && grp_sel[g]) begin
                    stage_q[g] <= diag_data_h;
                end
            end
            if (load_commit) begin
                stage_mark_q <= cram_mark_h;
            end
            dia_func_l  <= load_act ? ~grp_sel : '1;
            ebus_d_en_h <= read_act && (|grp_sel);
            ebus_d_e_h  <= (read_act && (|grp_sel)) ? rd_grp : '0;
        end
    end

endmodule

// File: tb/tb_crm_slice.sv
// Self-checking bench for crm_slice: decode vector table, commit/reset/parity
// sequences, and randomized traffic against a word-level RAM model.
module tb_crm_slice;
    import crm_pkg::*;

    logic        clk_crm_h;
    logic        mr_reset_h;
    logic [10:0] cra_adr_c_h;
    logic [2:0]  diag_func_h;
    logic        diag_load_func_l;
    logic        diag_read_func_l;
    logic [3:0]  diag_data_h;
    logic        cram_mark_h;
    logic [15:0] crm_word_h;
    logic        crm_mark_h;
    logic        cram_par_h;
    logic [3:0]  ebus_d_e_h;
    logic        ebus_d_en_h;
    logic [3:0]  dia_func_l;
    logic        crm_busy_h;
    logic        par_err_h;

    crm_slice dut (
        .clk_crm_h        (clk_crm_h),
        .mr_reset_h       (mr_reset_h),
        .cra_adr_c_h      (cra_adr_c_h),
        .diag_func_h      (diag_func_h),
        .diag_load_func_l (diag_load_func_l),
        .diag_read_func_l (diag_read_func_l),
        .diag_data_h      (diag_data_h),
        .cram_mark_h      (cram_mark_h),
        .crm_word_h       (crm_word_h),
        .crm_mark_h       (crm_mark_h),
        .cram_par_h       (cram_par_h),
        .ebus_d_e_h       (ebus_d_e_h),
        .ebus_d_en_h      (ebus_d_en_h),
        .dia_func_l       (dia_func_l),
        .crm_busy_h       (crm_busy_h),
        .par_err_h        (par_err_h)
    );

    initial begin
        clk_crm_h = 1'b0;
        forever #5 clk_crm_h = ~clk_crm_h;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_data [2048];
    logic        m_mark [2048];
    logic [3:0]  m_stage [4];

    typedef struct {
        logic [2:0] func;
        logic       load_l;
        logic       read_l;
        logic [3:0] data;
        logic [3:0] exp_dia;
        logic       exp_en;
        logic [3:0] exp_eb;
    } vec_t;

    vec_t vecs [12];

    function automatic logic ref_par(input logic [15:0] d, input logic m);
        return (($countones({m, d}) % 2) == 0);
    endfunction

    function automatic logic [15:0] stage_word();
        return {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
    endfunction

    task automatic step();
        @(posedge clk_crm_h);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] func, input logic load_l,
                                 input logic read_l, input logic [3:0] data);
        diag_func_h      = func;
        diag_load_func_l = load_l;
        diag_read_func_l = read_l;
        diag_data_h      = data;
        if (!load_l && func < 3'd4) m_stage[func[1:0]] = data;
    endtask

    task automatic checkWord(input string name, input logic [10:0] adr);
        checkOutput({name, "_word"}, 32'(crm_word_h), 32'(m_data[adr]));
        checkOutput({name, "_mark"}, 32'(crm_mark_h), 32'(m_mark[adr]));
        checkOutput({name, "_par"}, 32'(cram_par_h), 32'(ref_par(m_data[adr], m_mark[adr])));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_word"}, 32'(crm_word_h), 0);
        checkOutput({name, "_mark"}, 32'(crm_mark_h), 0);
        checkOutput({name, "_par"}, 32'(cram_par_h), 0);
        checkOutput({name, "_ebus"}, 32'(ebus_d_e_h), 0);
        checkOutput({name, "_ebus_en"}, 32'(ebus_d_en_h), 0);
        checkOutput({name, "_busy"}, 32'(crm_busy_h), 0);
        checkOutput({name, "_perr"}, 32'(par_err_h), 0);
        checkOutput({name, "_dia"}, 32'(dia_func_l), 32'hF);
        checkOutput({name, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    task automatic commitAt(input logic [10:0] adr, input logic mark,
                            input bit count_busy, input bit chk);
        int busy_cycles;
        cra_adr_c_h      = adr;
        cram_mark_h      = mark;
        diag_func_h      = FUNC_COMMIT;
        diag_load_func_l = 1'b0;
        diag_read_func_l = 1'b1;
        step();
        diag_load_func_l = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (crm_busy_h) busy_cycles++;
            step();
        end
        m_data[adr] = stage_word();
        m_mark[adr] = mark;
        if (count_busy) checkOutput("commit_busy_cycles", busy_cycles, 2);
        if (chk) checkWord("commit", adr);
    endtask

    logic [10:0] vis_adr, pend_adr, a;
    logic [15:0] old_word;
    int          f;
    logic        ll, rl;
    logic [3:0]  exp_dia, exp_eb;
    logic        exp_en;

    initial begin
        mr_reset_h       = 1'b1;
        cra_adr_c_h      = 11'h055;
        diag_func_h      = 3'd0;
        diag_load_func_l = 1'b0;
        diag_read_func_l = 1'b0;
        diag_data_h      = 4'h5;
        cram_mark_h      = 1'b1;
        for (int g = 0; g < 4; g++) m_stage[g] = 4'h0;

        // Reset state, with strobes active to confirm they are ignored
        step();
        step();
        checkAllZero("reset");
        mr_reset_h       = 1'b0;
        diag_load_func_l = 1'b1;
        diag_read_func_l = 1'b1;
        cram_mark_h      = 1'b0;

        // Fill the whole RAM through the commit path with partial staging reloads
        for (int adr = 0; adr < 2048; adr++) begin
            cra_adr_c_h = 11'(adr);
            applyStimulus(3'($urandom_range(0, 3)), 1'b0, 1'b1, 4'($urandom_range(0, 15)));
            step();
            commitAt(11'(adr), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        cra_adr_c_h = 11'h000;
        step();
        step();
        step();
        applyStimulus(FUNC_CLR_PERR, 1'b0, 1'b1, 4'h0);
        step();
        applyStimulus(3'd0, 1'b1, 1'b1, 4'h0);
        step();
        checkOutput("init_perr_cleared", 32'(par_err_h), 0);
        checkWord("init_adr0", 11'h000);

        // Stage 1,2,3,4 at 0x123 with mark set and commit
        cra_adr_c_h = 11'h123;
        for (int g = 0; g < 4; g++) begin
            applyStimulus(3'(g), 1'b0, 1'b1, 4'(g + 1));
            step();
        end
        commitAt(11'h123, 1'b1, 1'b1, 1'b1);
        checkOutput("commit_word_const", 32'(crm_word_h), 32'h4321);
        checkOutput("commit_mark_const", 32'(crm_mark_h), 1);
        checkOutput("commit_par_const", 32'(cram_par_h), 1);

        // Decode table, read-back of the 0x4321 word held at 0x123
        vecs[0]  = '{3'd0, 1'b0, 1'b1, 4'h5, 4'b1110, 1'b0, 4'h0};
        vecs[1]  = '{3'd1, 1'b0, 1'b0, 4'hF, 4'b1101, 1'b0, 4'h0};
        vecs[2]  = '{3'd2, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b1, 4'h3};
        vecs[3]  = '{3'd2, 1'b1, 1'b1, 4'h0, 4'b1111, 1'b0, 4'h0};
        vecs[4]  = '{3'd3, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b1, 4'h4};
        vecs[5]  = '{3'd0, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b1, 4'h1};
        vecs[6]  = '{3'd4, 1'b0, 1'b1, 4'h7, 4'b1111, 1'b0, 4'h0};
        vecs[7]  = '{3'd5, 1'b0, 1'b1, 4'h7, 4'b1111, 1'b0, 4'h0};
        vecs[8]  = '{3'd5, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b0, 4'h0};
        vecs[9]  = '{3'd6, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b0, 4'h0};
        vecs[10] = '{3'd3, 1'b0, 1'b1, 4'h8, 4'b0111, 1'b0, 4'h0};
        vecs[11] = '{3'd1, 1'b1, 1'b0, 4'h0, 4'b1111, 1'b1, 4'h2};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].func, vecs[i].load_l, vecs[i].read_l, vecs[i].data);
            step();
            checkOutput($sformatf("vec%0d_dia", i), 32'(dia_func_l), 32'(vecs[i].exp_dia));
            checkOutput($sformatf("vec%0d_en", i), 32'(ebus_d_en_h), 32'(vecs[i].exp_en));
            checkOutput($sformatf("vec%0d_ebus", i), 32'(ebus_d_e_h), 32'(vecs[i].exp_eb));
            if (i == 1) checkOutput("vec1_stage1", 32'(dut.stage_q[1]), 32'hF);
        end
        applyStimulus(3'd0, 1'b1, 1'b1, 4'h0);
        step();
        checkOutput("table_word_kept", 32'(crm_word_h), 32'h4321);

        // Group-0 load during WRITE and VERIFY must be ignored
        cra_adr_c_h      = 11'h200;
        cram_mark_h      = 1'b0;
        diag_func_h      = FUNC_COMMIT;
        diag_load_func_l = 1'b0;
        step();
        checkOutput("busy_in_write", 32'(crm_busy_h), 1);
        diag_func_h = 3'd0;
        diag_data_h = 4'hA;
        step();
        checkOutput("busy_load_dia_w", 32'(dia_func_l), 32'hF);
        step();
        diag_load_func_l = 1'b1;
        checkOutput("busy_load_dia_v", 32'(dia_func_l), 32'hF);
        checkOutput("busy_stage0", 32'(dut.stage_q[0]), 32'(m_stage[0]));
        m_data[11'h200] = stage_word();
        m_mark[11'h200] = 1'b0;
        step();
        checkWord("busy_commit", 11'h200);

        // Reset landing on the WRITE cycle aborts the commit
        cra_adr_c_h = 11'h300;
        old_word    = m_data[11'h300];
        applyStimulus(3'd2, 1'b0, 1'b1, ~old_word[11:8]);
        step();
        cram_mark_h      = 1'b1;
        diag_func_h      = FUNC_COMMIT;
        diag_load_func_l = 1'b0;
        step();
        checkOutput("rst_write_busy", 32'(crm_busy_h), 1);
        mr_reset_h       = 1'b1;
        diag_load_func_l = 1'b1;
        step();
        checkAllZero("rst_write");
        mr_reset_h = 1'b0;
        for (int g = 0; g < 4; g++) m_stage[g] = 4'h0;
        step();
        step();
        step();
        checkOutput("rst_write_word_kept", 32'(crm_word_h), 32'(old_word));
        checkWord("rst_write_after", 11'h300);
        checkOutput("rst_write_perr", 32'(par_err_h), 0);

        // Flipped data bit at 0x010
        dut.u_ram.mem[16] = {ref_par(m_data[16], m_mark[16]), m_mark[16], m_data[16] ^ 16'h0010};
        cra_adr_c_h = 11'h010;
        step();
        checkOutput("perr_before_word", 32'(par_err_h), 0);
        step();
        checkOutput("perr_bad_word", 32'(crm_word_h), 32'(m_data[16] ^ 16'h0010));
        checkOutput("perr_rise", 32'(par_err_h), 1);
        cra_adr_c_h = 11'h123;
        step();
        step();
        step();
        checkOutput("perr_hold", 32'(par_err_h), 1);
        applyStimulus(FUNC_CLR_PERR, 1'b0, 1'b1, 4'h0);
        step();
        applyStimulus(3'd0, 1'b1, 1'b1, 4'h0);
        checkOutput("perr_cleared", 32'(par_err_h), 0);
        step();
        checkOutput("perr_stay_clear", 32'(par_err_h), 0);

        // Randomized traffic with periodic commits
        vis_adr  = 11'h123;
        pend_adr = 11'h123;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 60) == 59) begin
                a = 11'($urandom_range(0, 2047));
                if (a == 11'h010) a = 11'h011;
                commitAt(a, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                vis_adr  = a;
                pend_adr = a;
            end else begin
                a = 11'($urandom_range(0, 2047));
                if (a == 11'h010) a = 11'h011;
                f  = $urandom_range(0, 5);
                ll = 1'($urandom_range(0, 1));
                rl = 1'($urandom_range(0, 1));
                exp_dia = (!ll && f < 4) ? ~(4'b0001 << f) : 4'hF;
                exp_en  = ll && !rl && (f < 4);
                exp_eb  = exp_en ? m_data[vis_adr][f*4 +: 4] : 4'h0;
                cra_adr_c_h = a;
                applyStimulus(3'(f), ll, rl, 4'($urandom_range(0, 15)));
                step();
                vis_adr  = pend_adr;
                pend_adr = a;
                checkWord("rnd", vis_adr);
                checkOutput("rnd_dia", 32'(dia_func_l), 32'(exp_dia));
                checkOutput("rnd_en", 32'(ebus_d_en_h), 32'(exp_en));
                checkOutput("rnd_ebus", 32'(ebus_d_e_h), 32'(exp_eb));
                checkOutput("rnd_perr", 32'(par_err_h), 0);
                checkOutput("rnd_busy", 32'(crm_busy_h), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crm_slice.md
CRM_SLICE -- requirements
Module: crm_slice

Interface
REQ-001 Parameters: ADR_W, default 11, CRAM address width; GRP_W, default 4, bits per diagnostic group; N_GRP, default 4, groups per slice (WORD_W = GRP_W*N_GRP); PAR_ODD, default 1, 1 = odd parity, 0 = even.
REQ-002 Clock and reset are fixed: one clock, clk_crm_h; reset mr_reset_h is synchronous and active-high.
REQ-003 Ports, in this order:
- clk_crm_h  in  1  slice clock.
- mr_reset_h  in  1  synchronous active-high master reset.
- cra_adr_c_h  in  ADR_W  microinstruction address.
- diag_func_h  in  3  diagnostic function low digit: group select 0..N_GRP-1; 7 = COMMIT.
- diag_load_func_l  in  1  active-low load strobe, qualified by diag_func_h.
- diag_read_func_l  in  1  active-low read strobe, qualified by diag_func_h.
- diag_data_h  in  GRP_W  diagnostic data group.
- cram_mark_h  in  1  mark bit, stored on COMMIT.
- crm_word_h  out  WORD_W  registered microword slice.
- crm_mark_h  out  1  stored mark bit of the current word.
- cram_par_h  out  1  parity over crm_word_h and crm_mark_h.
- ebus_d_e_h  out  GRP_W  diagnostic read data.
- ebus_d_en_h  out  1  ebus drive enable.
- dia_func_l  out  N_GRP  active-low one-hot echo of the group-load decode, one cycle.
- crm_busy_h  out  1  commit sequence in progress.
- par_err_h  out  1  sticky parity error.

Function
REQ-004 Storage: 2^ADR_W entries of {parity, mark, WORD_W data}; synchronous read; single write port.
REQ-005 Normal read: cra_adr_c_h is registered on each clock. crm_word_h, crm_mark_h and cram_par_h are valid 2 cycles after the address is presented (address register, then RAM output register).
REQ-006 Parity is generated at write time per PAR_OPD/PAR_ODD selection: with PAR_ODD=1, the number of ones over {mark, data, parity} is odd. cram_par_h outputs the stored parity bit.
REQ-007 Parity check on each read: mismatch sets par_err_h in the same cycle the word appears. par_err_h stays set until reset. A diagnostic load with diag_func_h=6 also clears it.
REQ-008 Group load: diag_load_func_l low with func < N_GRP, in state IDLE, writes diag_data_h into staging group[func]. dia_func_l[func] goes low for the next cycle.
- func values in N_GRP..5 are no-ops.
- When func is outside 0..N_GRP-1, dia_func_l stays all-ones.
REQ-009 Commit FSM states and transitions:
- IDLE: load with func=7 stores cram_mark_h into staging and moves to WRITE.
- WRITE: one cycle; write staging to RAM at the registered address, with generated parity; move to VERIFY.
- VERIFY: one cycle; read back, run the parity check; move to IDLE.
REQ-010 crm_busy_h is high in WRITE and VERIFY only.
- Any load or read strobe while busy is ignored.
- Staging and the address register are frozen while busy.
REQ-011 Diagnostic read: diag_read_func_l low with func < N_GRP, in IDLE, registers group[func] of the current crm_word_h onto ebus_d_e_h. ebus_d_en_h is high the next cycle only. Otherwise ebus_d_e_h = 0 and ebus_d_en_h = 0.
REQ-012 Load and read strobes asserted in the same cycle: the load is performed and the read is ignored (ebus_d_en_h stays 0).
REQ-013 Staging persists after a commit, so partial reloads are allowed.
REQ-014 Address wrap: no special case; all 2^ADR_W addresses are valid.

Reset
REQ-015 While mr_reset_h is high at a clock edge, the following are all cleared to 0:
- FSM state (IDLE), staging, address register;
- crm_word_h, crm_mark_h, cram_par_h, ebus_d_e_h, ebus_d_en_h, crm_busy_h, par_err_h.
dia_func_l is set to all-ones.
REQ-016 Reset in WRITE aborts the commit; the RAM write in that cycle is suppressed. Reset in VERIFY returns the FSM to IDLE. RAM contents are never cleared.
REQ-017 The first valid word appears 2 cycles after reset deasserts.

Structure
REQ-018 A shared package crm_pkg holds:
- the commit FSM state enum;
- the diag_func codes COMMIT=7 and CLR_PERR=6;
- the parity function.
REQ-019 The storage array is one sub-module, crm_ram (synchronous read, write enable, parameterised width and depth). All control stays in crm_slice.

Verification
REQ-020 Load groups 0..3 with 1,2,3,4 at address 0x123, mark=1, then COMMIT. Required: crm_busy_h is high for exactly 2 cycles, and reading 0x123 gives crm_word_h=0x4321, crm_mark_h=1, cram_par_h=1 (odd).
REQ-021 Diag read of func=2 on word 0x4321. Required: ebus_d_e_h=3 and ebus_d_en_h=1 for exactly one cycle, then both 0.
REQ-022 Force a flipped data bit in crm_ram at 0x010, then read 0x010. Required: par_err_h rises and holds; a load with func=6 clears it.
REQ-023 Load and read strobes in the same cycle, func=1, data=0xF. Required: group 1 is staged, dia_func_l=4'b1101 the next cycle, ebus_d_en_h=0.
REQ-024 Assert mr_reset_h during WRITE. Required: the target address is unchanged, all outputs are 0, dia_func_l is all-ones, and the FSM is in IDLE.
REQ-025 A load with func=0 while busy. Required: staging group 0 is unchanged and dia_func_l stays all-ones.
